// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and counter sizing.
package divisor_pkg;

   localparam int unsigned LARGURA_PADRAO = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIM  = 2'd2
   } estado_t;

   function automatic int unsigned largura_contador(input int unsigned largura);
      return (largura > 1) ? $clog2(largura) : 1;
   endfunction

endpackage

// File: rtl/subtrator.sv
// Two's-complement subtractor in the Adder style: Diferenca = A + ~B + 1,
// with the MSB exposed as the sign of the result.
module subtrator #(
   parameter int unsigned LARGURA = 17
) (
   input  logic [LARGURA-1:0] A,
   input  logic [LARGURA-1:0] B,
   output logic [LARGURA-1:0] Diferenca,
   output logic               Sinal
);

   always_comb begin
      Diferenca = A + ~B + LARGURA'(1);
      Sinal     = Diferenca[LARGURA-1];
   end

endmodule

// File: rtl/divisor_sequencial.sv
// Unsigned restoring divider, one quotient bit per clock, Start/Done handshake.
// Divide-by-zero skips CALC and returns all-ones quotient, dividend remainder.
module divisor_sequencial
   import divisor_pkg::*;
#(
   parameter int unsigned LARGURA = LARGURA_PADRAO
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [LARGURA-1:0] Dividendo,
   input  logic [LARGURA-1:0] Divisor,
   output logic [LARGURA-1:0] Quociente,
   output logic [LARGURA-1:0] Resto,
   output logic               Busy,
   output logic               Done,
   output logic               DivZero
);

   localparam int unsigned CW = largura_contador(LARGURA);

   estado_t            estado, estado_prox;
   logic [LARGURA:0]   r, r_shift, r_prox, diferenca;
   logic [LARGURA-1:0] q, q_prox, divisor_reg;
   logic [CW-1:0]      contador;
   logic               sinal;

   subtrator #(.LARGURA(LARGURA + 1)) u_subtrator (
      .A         (r_shift),
      .B         ({1'b0, divisor_reg}),
      .Diferenca (diferenca),
      .Sinal     (sinal)
   );

   // r's MSB is always 0 after a restore step, so it falls off the shift.
   always_comb begin
      r_shift = (LARGURA + 1)'({r, q[LARGURA-1]});
      r_prox  = sinal ? r_shift : diferenca;
      q_prox  = {q[LARGURA-2:0], ~sinal};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) estado <= IDLE;
      else       estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      Busy        = 1'b0;
      Done        = 1'b0;
      case (estado)
         IDLE: begin
            if (Start) estado_prox = (Divisor == '0) ? FIM : CALC;
         end
         CALC: begin
            Busy = 1'b1;
            if (contador == '0) estado_prox = FIM;
         end
         FIM: begin
            Busy        = 1'b1;
            Done        = 1'b1;
            estado_prox = IDLE;
         end
         default: estado_prox = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r           <= '0;
         q           <= '0;
         divisor_reg <= '0;
         contador    <= '0;
         Quociente   <= '0;
         Resto       <= '0;
         DivZero     <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               if (Start) begin
                  if (Divisor != '0) begin
                     divisor_reg <= Divisor;
                     r           <= '0;
                     q           <= Dividendo;
                     contador    <= CW'(LARGURA - 1);
                     DivZero     <= 1'b0;
                  end else begin
                     Quociente <= '1;
                     Resto     <= Dividendo;
                     DivZero   <= 1'b1;
                  end
               end
            end
            CALC: begin
               r        <= r_prox;
               q        <= q_prox;
               contador <= contador - CW'(1);
               if (contador == '0) begin
                  Quociente <= q_prox;
                  Resto     <= r_prox[LARGURA-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
Sequential unsigned 16-bit restoring divider, the inverse companion of the multiplier datapath (shift-and-add multiply ↔ shift-and-subtract divide). It sits beside the multiplier in the CPU-MIPS execute stage and serves DIVU-style operations. It produces one quotient bit per clock with a Start/Done handshake and reuses a 17-bit subtractor built the same way as the existing Adder.

Parameters:
LARGURA, 16, operand width in bits; quotient and remainder have the same width.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  request a division; sampled only in IDLE
Dividendo  input  LARGURA  dividend, latched on the accepting edge
Divisor  input  LARGURA  divisor, latched on the accepting edge
Quociente  output  LARGURA  quotient; held stable from Done until the next accepted Start
Resto  output  LARGURA  remainder; held like Quociente
Busy  output  1  high from the cycle after acceptance until Done deasserts
Done  output  1  one-cycle pulse marking valid results
DivZero  output  1  set with Done when Divisor==0; held until the next accepted Start

Behaviour:
- Reset (async, any time, including mid-division): state=IDLE; Quociente, Resto, Busy, Done, DivZero = 0; internal registers = 0.
- States: IDLE, CALC, FIM.
- IDLE, Start=1, Divisor!=0: latch operands, R=0 (17 bits), Q=Dividendo, contador=LARGURA-1, clear DivZero → CALC.
- IDLE, Start=1, Divisor==0: Quociente=all ones (0xFFFF), Resto=Dividendo, DivZero=1 → FIM. No CALC cycles.
- IDLE, Start=0: hold. Outputs keep their last results.
- CALC, each cycle: shift {R,Q} left by 1, with Q's MSB moving into R's LSB. Compute T=R_shift−{0,Divisor} using the 17-bit subtractor.
  - If T is non-negative (bit 16 = 0): R=T, Q LSB=1.
  - Otherwise: keep R_shift, Q LSB=0.
  - Decrement contador. When contador==0, load Quociente=Q and Resto=R[15:0], then → FIM.
- CALC runs exactly LARGURA (16) cycles.
- FIM: Done=1 for exactly this cycle → IDLE. Start is ignored in FIM.
- Busy=1 in CALC and FIM.
- Latency: Done is high in the cycle after the 17th rising edge following the accepting edge, i.e., 1 edge to CALC + 16 CALC edges. For divide-by-zero, Done is high after 1 edge.
- Start held high continuously: a new division is accepted on each return to IDLE, giving a throughput of one division per 18 cycles.
- Start while Busy: ignored. Operand changes while Busy do not affect the result.
- All arithmetic is unsigned. The invariant Dividendo = Quociente*Divisor + Resto, with Resto < Divisor, must hold for every Divisor != 0.

Decomposition:
- Shared package divisor_pkg: LARGURA default, state encoding constants (IDLE=2'd0, CALC=2'd1, FIM=2'd2), counter width $clog2(LARGURA).
- One sub-module: subtrator (17-bit, Diferenca = A + ~B + 1, exposes bit 16 as sign). It mirrors the existing Adder interface style and lets the Adder bench be reused.
- Top: FSM, counter, shift registers, output registers.

Test Plan:
- 100/7: Start pulse → Done after 17 edges; Quociente=14, Resto=2, DivZero=0; Busy high for the intervening cycles.
- 0xFFFF/1 → Quociente=0xFFFF, Resto=0. 0xFFFF/0xFFFF → Quociente=1, Resto=0. 3/10 → Quociente=0, Resto=3.
- 5/0 → Done after 1 edge; Quociente=0xFFFF, Resto=5, DivZero=1. A following 9/3 → DivZero=0, Quociente=3, Resto=0.
- Start re-pulsed at cycle 5 of 1000/3 with operands changed to 8/2 → ignored; result Quociente=333, Resto=1; only one Done pulse.
- Reset asserted at cycle 8 of 50000/123 → all outputs 0 immediately, state IDLE. A new 50000/123 after release → Quociente=406, Resto=62.
- Sweep i,j in 0..15 (j≠0), plus 200 random pairs → check the invariant against a reference model; every Done is a single-cycle pulse.
